gates2_checker: RTL and testbench

GATES2_CHECKER -- requirements
Module: gates2_checker

---
 rtl/gates2_pkg.sv | 38 +++
 rtl/gates2_ref.sv | 13 +
 rtl/gates2_checker.sv | 128 ++++++++++++
 tb/tb_gates2_checker.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/gates2_pkg.sv
// Shared definitions for the gates2 checker: z bit positions, FSM encoding
// and the golden expected-z function used by the reference model.
package gates2_pkg;

  localparam int Z_W     = 6;
  localparam int Z_AND   = 5;
  localparam int Z_NAND  = 4;
  localparam int Z_OR    = 3;
  localparam int Z_NOR   = 2;
  localparam int Z_XOR   = 1;
  localparam int Z_XNOR  = 0;

  localparam int NUM_VEC = 4;
  localparam int IDX_W   = 2;
  localparam int CNT_W   = 4;
  localparam int ERR_W   = 3;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    WAIT,
    CHECK,
    FINISH
  } state_t;

  function automatic logic [Z_W-1:0] expectedZ(input logic a, input logic b);
    logic [Z_W-1:0] z;
    z         = '0;
    z[Z_AND]  = a & b;
    z[Z_NAND] = ~(a & b);
    z[Z_OR]   = a | b;
    z[Z_NOR]  = ~(a | b);
    z[Z_XOR]  = a ^ b;
    z[Z_XNOR] = ~(a ^ b);
    return z;
  endfunction

endpackage

// File: rtl/gates2_ref.sv
// Golden combinational model of the gates2 unit: maps one {a,b} vector
// to the six gate outputs the checker expects to see on z.
module gates2_ref
  import gates2_pkg::*;
(
  input  logic           i_a,
  input  logic           i_b,
  output logic [Z_W-1:0] o_z
);

  assign o_z = expectedZ(i_a, i_b);

endmodule

// File: rtl/gates2_checker.sv
// Sweeps all four {a,b} vectors into an external gates2 unit, compares its z
// outputs against the golden model and reports per-vector mismatches.
module gates2_checker #(
  parameter int SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] z,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  import gates2_pkg::*;

  state_t             r_state;
  state_t             w_stateNext;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_a;
  logic               r_b;
  logic               r_done;
  logic               r_pass;
  logic [ERR_W-1:0]   r_errCount;
  logic [NUM_VEC-1:0] r_failVec;

  logic [Z_W-1:0]     w_expZ;
  logic               w_mismatch;
  logic [NUM_VEC-1:0] w_failNext;

  // Expected value is derived from the vector index, not from the a/b
  // outputs, so a corrupted stimulus path also shows up as a mismatch.
  gates2_ref u_ref (
    .i_a (r_idx[1]),
    .i_b (r_idx[0]),
    .o_z (w_expZ)
  );

  always_comb begin
    w_mismatch = (z != w_expZ);
    w_failNext = r_failVec;
    if (w_mismatch) begin
      w_failNext[r_idx] = 1'b1;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    unique case (r_state)
      IDLE:    if (start) w_stateNext = APPLY;
      APPLY:   w_stateNext = WAIT;
      WAIT:    if (r_cnt == '0) w_stateNext = CHECK;
      CHECK:   w_stateNext = (r_idx == IDX_W'(NUM_VEC - 1)) ? FINISH : APPLY;
      FINISH:  w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_a        <= 1'b0;
      r_b        <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_errCount <= '0;
      r_failVec  <= '0;
    end else begin
      r_state <= w_stateNext;
      r_done  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_idx      <= '0;
            r_errCount <= '0;
            r_failVec  <= '0;
            r_pass     <= 1'b0;
          end
        end
        APPLY: begin
          r_a   <= r_idx[1];
          r_b   <= r_idx[0];
          r_cnt <= CNT_W'(SETTLE_CYC - 1);
        end
        WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        CHECK: begin
          // At most one increment per vector, so the count tops out at 4.
          if (w_mismatch) begin
            r_failVec  <= w_failNext;
            r_errCount <= r_errCount + 1'b1;
          end
          if (r_idx == IDX_W'(NUM_VEC - 1)) begin
            r_done <= 1'b1;
            r_pass <= (w_failNext == '0);
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        FINISH: begin
          r_a   <= 1'b0;
          r_b   <= 1'b0;
          r_idx <= '0;
        end
        default: ;
      endcase
    end
  end

  assign a         = r_a;
  assign b         = r_b;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_errCount;
  assign fail_vec  = r_failVec;

endmodule

// File: tb/tb_gates2_checker.sv
// Bench for gates2_checker: two instances (settle 2 and settle 1) each driven
// by a modelled gates2 unit with selectable faults; sweep results are scoreboarded.
module tb_gates2_checker;

  logic clk = 1'b0;
  logic reset;
  logic startA, startB;
  logic [5:0] zA, zB;
  logic aA, bA, busyA, doneA, passA;
  logic aB, bB, busyB, doneB, passB;
  logic [2:0] errA, errB;
  logic [3:0] failA, failB;

  int modeA = 0;
  int modeB = 0;
  logic glitchA = 1'b0;
  logic glitchB = 1'b0;

  int vecCount = 0;
  int missCount = 0;

  typedef struct {
    logic       pass;
    logic [2:0] err;
    logic [3:0] fail;
    int         doneCyc;
  } sweepExp_t;

  sweepExp_t expQ[$];

  int tbSel = 0;
  logic oA, oB, oBusy, oDone, oPass;
  logic [2:0] oErr;
  logic [3:0] oFail;

  always #5 clk = ~clk;

  gates2_checker #(.SETTLE_CYC(2)) dutA (
    .clk(clk), .reset(reset), .start(startA), .z(zA),
    .a(aA), .b(bA), .busy(busyA), .done(doneA), .pass(passA),
    .err_count(errA), .fail_vec(failA)
  );

  gates2_checker #(.SETTLE_CYC(1)) dutB (
    .clk(clk), .reset(reset), .start(startB), .z(zB),
    .a(aB), .b(bB), .busy(busyB), .done(doneB), .pass(passB),
    .err_count(errB), .fail_vec(failB)
  );

  // Modes of the modelled gates2 unit: 0 correct, 1 XOR stuck-at-0,
  // 2 every output inverted, 3 correct but forced to zero while settling.
  function automatic logic [5:0] goodZ(input logic a, input logic b);
    return {a & b, ~(a & b), a | b, ~(a | b), a ^ b, ~(a ^ b)};
  endfunction

  function automatic logic [5:0] uutZ(input int mode, input logic a, input logic b,
                                      input logic glitch);
    logic [5:0] g;
    g = goodZ(a, b);
    if (mode == 1) g[1] = 1'b0;
    if (mode == 2) g = ~g;
    if (glitch) g = '0;
    return g;
  endfunction

  always_comb zA = uutZ(modeA, aA, bA, glitchA);
  always_comb zB = uutZ(modeB, aB, bB, glitchB);

  always_comb begin
    if (tbSel == 0) begin
      oA = aA; oB = bA; oBusy = busyA; oDone = doneA;
      oPass = passA; oErr = errA; oFail = failA;
    end else begin
      oA = aB; oB = bB; oBusy = busyB; oDone = doneB;
      oPass = passB; oErr = errB; oFail = failB;
    end
  end

  task automatic checkOutput(input string tag, input int got, input int exp);
    vecCount++;
    if (got != exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".ab"},   {oA, oB}, 0);
    checkOutput({tag, ".busy"}, oBusy, 0);
    checkOutput({tag, ".done"}, oDone, 0);
    checkOutput({tag, ".pass"}, oPass, 0);
    checkOutput({tag, ".err"},  oErr, 0);
    checkOutput({tag, ".fail"}, oFail, 0);
  endtask

  task automatic driveStart(input int sel, input logic v);
    if (sel == 0) startA = v; else startB = v;
  endtask

  task automatic driveGlitch(input int sel, input logic v);
    if (sel == 0) glitchA = v; else glitchB = v;
  endtask

  // Pushes the expected sweep outcome, then pulses start so that it is
  // sampled at edge 0; returns in the middle of cycle 1.
  task automatic applyStimulus(input int sel, input int mode);
    sweepExp_t e;
    logic [3:0] fv;
    logic [1:0] v;
    int ec;
    int s;
    fv = '0;
    ec = 0;
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      if (uutZ(mode, v[1], v[0], 1'b0) != goodZ(v[1], v[0])) begin
        fv[i] = 1'b1;
        ec++;
      end
    end
    s = (sel == 0) ? 2 : 1;
    e.pass    = (ec == 0);
    e.err     = 3'(ec);
    e.fail    = fv;
    e.doneCyc = 4 * (s + 2) + 1;
    expQ.push_back(e);
    if (sel == 0) modeA = mode; else modeB = mode;
    @(negedge clk);
    driveStart(sel, 1'b1);
    @(negedge clk);
    driveStart(sel, 1'b0);
  endtask

  task automatic runSweep(input int sel, input int mode, input int extraAt,
                          input int resetAt);
    int s, per, doneExp, doneCnt, doneAt, pos, expAb;
    logic aborted;
    sweepExp_t cur;
    tbSel   = sel;
    s       = (sel == 0) ? 2 : 1;
    per     = s + 2;
    doneExp = 4 * per + 1;
    doneCnt = 0;
    doneAt  = 0;
    aborted = 1'b0;
    cur     = '{pass: 1'b0, err: 3'd0, fail: 4'd0, doneCyc: 0};
    applyStimulus(sel, mode);
    for (int k = 1; k <= doneExp + 3; k++) begin
      if (k > 1) @(negedge clk);
      if (resetAt != 0 && k == resetAt + 1) begin
        reset = 1'b0;
        if (expQ.size() > 0) cur = expQ.pop_front();
        checkAllZero("abort");
        aborted = 1'b1;
        break;
      end
      pos = (k - 1) % per;
      driveGlitch(sel, (mode == 3) && (k <= 4 * per) && (pos >= 1) && (pos <= s));
      expAb = (k >= 2 && k <= doneExp) ? (k - 2) / per : 0;
      checkOutput("ab", {oA, oB}, expAb);
      checkOutput("busy", oBusy, (k <= doneExp) ? 1 : 0);
      if (oDone) begin
        doneCnt++;
        if (doneAt == 0) begin
          doneAt = k;
          if (expQ.size() > 0) cur = expQ.pop_front();
          checkOutput("doneCycle", k, cur.doneCyc);
          checkOutput("pass", oPass, cur.pass);
          checkOutput("errCount", oErr, cur.err);
          checkOutput("failVec", oFail, cur.fail);
        end
      end
      driveStart(sel, k == extraAt);
      if (resetAt != 0 && k == resetAt) reset = 1'b1;
    end
    driveStart(sel, 1'b0);
    driveGlitch(sel, 1'b0);
    if (!aborted) begin
      checkOutput("doneCount", doneCnt, 1);
      if (doneAt == 0 && expQ.size() > 0) cur = expQ.pop_front();
      checkOutput("holdPass", oPass, cur.pass);
      checkOutput("holdErr", oErr, cur.err);
      checkOutput("holdFail", oFail, cur.fail);
    end
  endtask

  initial begin
    reset  = 1'b1;
    startA = 1'b0;
    startB = 1'b0;
    repeat (3) @(negedge clk);
    tbSel = 0;
    checkAllZero("resetA");
    tbSel = 1;
    checkAllZero("resetB");
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] clean sweep, start repeated during FINISH");
    runSweep(0, 0, 17, 0);
    $display("[TB] clean sweep, start repeated at cycle 6");
    runSweep(0, 0, 6, 0);
    $display("[TB] XOR output stuck at 0");
    runSweep(0, 1, 0, 0);
    $display("[TB] all outputs inverted");
    runSweep(0, 2, 0, 0);
    $display("[TB] reset in cycle 9 of a faulty sweep");
    runSweep(0, 2, 0, 9);
    $display("[TB] clean sweep after reset");
    runSweep(0, 0, 0, 0);
    $display("[TB] settle 1, z forced low while settling");
    runSweep(1, 3, 0, 0);
    $display("[TB] settle 1, XOR output stuck at 0");
    runSweep(1, 1, 0, 0);

    checkOutput("scoreboardEmpty", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
